// File: rtl/l1_mem_arbiter_if.sv
// Shared lower-memory bundle: two L1 requester ports, one memory port,
// plus arbiter status. The arbiter takes the slave view.
interface l1_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  c0_mem_request;
  logic                  c0_mem_write_enable;
  logic [ADDR_WIDTH-1:0] c0_mem_address;
  logic [DATA_WIDTH-1:0] c0_mem_write_data;
  logic [DATA_WIDTH-1:0] c0_mem_response_data;
  logic                  c0_mem_ready;

  logic                  c1_mem_request;
  logic                  c1_mem_write_enable;
  logic [ADDR_WIDTH-1:0] c1_mem_address;
  logic [DATA_WIDTH-1:0] c1_mem_write_data;
  logic [DATA_WIDTH-1:0] c1_mem_response_data;
  logic                  c1_mem_ready;

  logic                  mem_request;
  logic                  mem_write_enable;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_write_data;
  logic [DATA_WIDTH-1:0] mem_response_data;
  logic                  mem_ready;

  logic                  owner;
  logic                  busy;
  logic                  timeout_err;

  modport slave (
    input  c0_mem_request,
    input  c0_mem_write_enable,
    input  c0_mem_address,
    input  c0_mem_write_data,
    output c0_mem_response_data,
    output c0_mem_ready,
    input  c1_mem_request,
    input  c1_mem_write_enable,
    input  c1_mem_address,
    input  c1_mem_write_data,
    output c1_mem_response_data,
    output c1_mem_ready,
    output mem_request,
    output mem_write_enable,
    output mem_address,
    output mem_write_data,
    input  mem_response_data,
    input  mem_ready,
    output owner,
    output busy,
    output timeout_err
  );

  modport master (
    output c0_mem_request,
    output c0_mem_write_enable,
    output c0_mem_address,
    output c0_mem_write_data,
    input  c0_mem_response_data,
    input  c0_mem_ready,
    output c1_mem_request,
    output c1_mem_write_enable,
    output c1_mem_address,
    output c1_mem_write_data,
    input  c1_mem_response_data,
    input  c1_mem_ready,
    input  mem_request,
    input  mem_write_enable,
    input  mem_address,
    input  mem_write_data,
    output mem_response_data,
    output mem_ready,
    input  owner,
    input  busy,
    input  timeout_err
  );
endinterface

// File: rtl/l1_mem_arbiter.sv
// Two-to-one L1 (icache=0, dcache=1) arbiter onto one lower-memory port,
// with registered memory-side outputs and a per-transaction watchdog.
module l1_mem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int PRIORITY_MODE  = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic             clk,
  input logic             reset,
  l1_mem_arbiter_if.slave bus
);
  localparam int CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
  localparam bit FIXED = (PRIORITY_MODE != 0);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t                state;
  logic                  rr;
  logic                  guard_vld;
  logic                  guard_port;
  logic [CW-1:0]         cnt;

  logic                  mreq_q;
  logic                  mwe_q;
  logic [ADDR_WIDTH-1:0] maddr_q;
  logic [DATA_WIDTH-1:0] mwd_q;
  logic                  own_q;
  logic                  busy_q;
  logic                  terr_q;

  logic [1:0]            elig;
  logic                  win;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wd;
  logic                  fin_ok;
  logic                  fin_to;
  logic                  done;
  logic                  rdy_live;

  // The port served last is masked for one IDLE cycle after completion.
  always_comb begin
    elig[0] = bus.c0_mem_request &
              ~(guard_vld & ~guard_port);
    elig[1] = bus.c1_mem_request &
              ~(guard_vld & guard_port);
  end

  always_comb begin
    win = 1'b0;
    unique case (1'b1)
      elig == 2'b11: win = FIXED ? 1'b1 : rr;
      elig == 2'b10: win = 1'b1;
      default:       win = 1'b0;
    endcase
  end

  always_comb begin
    sel_we   = win ? bus.c1_mem_write_enable
                   : bus.c0_mem_write_enable;
    sel_addr = win ? bus.c1_mem_address
                   : bus.c0_mem_address;
    sel_wd   = win ? bus.c1_mem_write_data
                   : bus.c0_mem_write_data;
  end

  // A mem_ready in the expiry cycle wins over the watchdog.
  always_comb begin
    fin_ok   = (state == BUSY) & bus.mem_ready;
    fin_to   = (state == BUSY) & ~bus.mem_ready &
               WD_EN & (cnt == CNT_LAST);
    done     = fin_ok | fin_to;
    rdy_live = done & ~reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rr         <= 1'b0;
      guard_vld  <= 1'b0;
      guard_port <= 1'b0;
      cnt        <= '0;
      mreq_q     <= 1'b0;
      mwe_q      <= 1'b0;
      maddr_q    <= '0;
      mwd_q      <= '0;
      own_q      <= 1'b0;
      busy_q     <= 1'b0;
      terr_q     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          guard_vld <= 1'b0;
          if (|elig) begin
            state   <= BUSY;
            mreq_q  <= 1'b1;
            mwe_q   <= sel_we;
            maddr_q <= sel_addr;
            mwd_q   <= sel_wd;
            own_q   <= win;
            busy_q  <= 1'b1;
            cnt     <= '0;
          end
        end
        BUSY: begin
          if (done) begin
            state      <= IDLE;
            mreq_q     <= 1'b0;
            mwe_q      <= 1'b0;
            busy_q     <= 1'b0;
            rr         <= ~own_q;
            guard_vld  <= 1'b1;
            guard_port <= own_q;
            if (fin_to) terr_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_request      = mreq_q;
  assign bus.mem_write_enable = mwe_q;
  assign bus.mem_address      = maddr_q;
  assign bus.mem_write_data   = mwd_q;
  assign bus.owner            = own_q;
  assign bus.busy             = busy_q;
  assign bus.timeout_err      = terr_q;

  assign bus.c0_mem_ready = rdy_live & ~own_q;
  assign bus.c1_mem_ready = rdy_live & own_q;

  assign bus.c0_mem_response_data =
    (rdy_live & ~own_q & fin_ok) ? bus.mem_response_data : '0;
  assign bus.c1_mem_response_data =
    (rdy_live & own_q & fin_ok) ? bus.mem_response_data : '0;
endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Bench for l1_mem_arbiter: two instances (round-robin with watchdog,
// fixed-priority without) under random caches and memory.
module tb_l1_mem_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        c_req  [2][2];
  logic        c_we   [2][2];
  logic [31:0] c_addr [2][2];
  logic [31:0] c_wd   [2][2];
  logic        c_rdy  [2][2];
  logic [31:0] c_rd   [2][2];
  logic        mem_rdy[2];
  logic [31:0] mem_rd [2];
  logic        mreq [2];
  logic        mwe  [2];
  logic [31:0] maddr[2];
  logic [31:0] mwd  [2];
  logic        own  [2];
  logic        bsy  [2];
  logic        terr [2];

  l1_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
  l1_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();

`define HOOK(B, K) \
  assign B.c0_mem_request      = c_req[K][0]; \
  assign B.c0_mem_write_enable = c_we[K][0]; \
  assign B.c0_mem_address      = c_addr[K][0]; \
  assign B.c0_mem_write_data   = c_wd[K][0]; \
  assign B.c1_mem_request      = c_req[K][1]; \
  assign B.c1_mem_write_enable = c_we[K][1]; \
  assign B.c1_mem_address      = c_addr[K][1]; \
  assign B.c1_mem_write_data   = c_wd[K][1]; \
  assign B.mem_ready           = mem_rdy[K]; \
  assign B.mem_response_data   = mem_rd[K]; \
  assign c_rdy[K][0] = B.c0_mem_ready; \
  assign c_rdy[K][1] = B.c1_mem_ready; \
  assign c_rd[K][0]  = B.c0_mem_response_data; \
  assign c_rd[K][1]  = B.c1_mem_response_data; \
  assign mreq[K]  = B.mem_request; \
  assign mwe[K]   = B.mem_write_enable; \
  assign maddr[K] = B.mem_address; \
  assign mwd[K]   = B.mem_write_data; \
  assign own[K]   = B.owner; \
  assign bsy[K]   = B.busy; \
  assign terr[K]  = B.timeout_err;

  `HOOK(bus0, 0)
  `HOOK(bus1, 1)
`undef HOOK

  l1_mem_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .PRIORITY_MODE(0), .TIMEOUT_CYCLES(8)
  ) u_rr (
    .clk(clk), .reset(reset), .bus(bus0)
  );

  l1_mem_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .PRIORITY_MODE(1), .TIMEOUT_CYCLES(0)
  ) u_fp (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  localparam int PM[2] = '{0, 1};
  localparam int TO[2] = '{8, 0};

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string tag, input int k,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d cyc%0d: got %0h, expected %0h",
               tag, k, cyc, got, exp);
    end
  endtask

  // Reference model: one outstanding transaction per instance.
  bit          m_busy [2];
  int          m_own  [2];
  int          m_rr   [2];
  int          m_guard[2];
  int          m_wait [2];
  bit          m_we   [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_wd   [2];
  bit          m_terr [2];
  int          n_done [2][2];

  bit hold[2][2];
  bit got_r[2][2];
  int lat_left[2];

  int p_req[2];
  int fixed_mode;
  int lat_min, lat_max;
  bit data_fixed;
  bit chk_en;

  task automatic model_reset(input int k);
    m_busy[k]  = 0;
    m_own[k]   = 0;
    m_rr[k]    = 0;
    m_guard[k] = -1;
    m_wait[k]  = 0;
    m_we[k]    = 0;
    m_addr[k]  = '0;
    m_wd[k]    = '0;
    m_terr[k]  = 0;
  endtask

  task automatic drive_cache(input int k, input int p,
                             input bit rst_now);
    if (rst_now) begin
      c_req[k][p] = 0;
      hold[k][p]  = 0;
      got_r[k][p] = 0;
      return;
    end
    if (got_r[k][p]) begin
      got_r[k][p] = 0;
      if ($urandom_range(1, 0) == 1) hold[k][p] = 1;
      else c_req[k][p] = 0;
    end else if (hold[k][p]) begin
      hold[k][p]  = 0;
      c_req[k][p] = 0;
    end
    if (!c_req[k][p] && $urandom_range(99, 0) < p_req[p]) begin
      c_req[k][p] = 1;
      if (fixed_mode == 1) begin
        c_we[k][p]   = 0;
        c_addr[k][p] = 32'h0000_0100;
        c_wd[k][p]   = '0;
      end else if (fixed_mode == 2) begin
        c_we[k][p]   = (p == 1);
        c_addr[k][p] = (p == 1) ? 32'h300 : 32'h200;
        c_wd[k][p]   = (p == 1) ? 32'h1234_5678 : 32'h0;
      end else begin
        c_we[k][p]   = $urandom_range(1, 0) == 1;
        c_addr[k][p] = $urandom & 32'hFFFF_FFFC;
        c_wd[k][p]   = $urandom;
      end
    end
  endtask

  task automatic drive_mem(input int k);
    mem_rd[k] = data_fixed ? 32'hDEAD_BEEF : $urandom;
    if (lat_left[k] == 0) begin
      mem_rdy[k]  = 1;
      lat_left[k] = -1;
    end else begin
      mem_rdy[k] = !m_busy[k] && lat_left[k] < 0 &&
                   $urandom_range(99, 0) < 5;
      if (lat_left[k] > 0) lat_left[k]--;
    end
  endtask

  task automatic cycle(input bit rst_now);
    bit ok, to, fin, e0, e1;
    int w;
    logic [31:0] ed;
    @(negedge clk);
    cyc++;
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check("mem_request", k, mreq[k], m_busy[k]);
        check("busy", k, bsy[k], m_busy[k]);
        check("timeout_err", k, terr[k], m_terr[k]);
        check("mem_we", k, mwe[k], m_we[k]);
        check("mem_addr", k, maddr[k], m_addr[k]);
        check("mem_wdata", k, mwd[k], m_wd[k]);
        if (m_busy[k]) check("owner", k, own[k], m_own[k]);
      end
    end
    reset = rst_now;
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 2; p++) drive_cache(k, p, rst_now);
      drive_mem(k);
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      ok  = !rst_now && m_busy[k] && mem_rdy[k];
      to  = !rst_now && m_busy[k] && !mem_rdy[k] &&
            TO[k] > 0 && m_wait[k] + 1 == TO[k];
      fin = ok || to;
      ed  = ok ? mem_rd[k] : 32'h0;
      for (int p = 0; p < 2; p++) begin
        check("ready", k, c_rdy[k][p], fin && m_own[k] == p);
        check("rdata", k, c_rd[k][p],
              (fin && m_own[k] == p) ? ed : 32'h0);
        if (c_rdy[k][p] && !rst_now) got_r[k][p] = 1;
      end
      if (rst_now) begin
        model_reset(k);
      end else if (m_busy[k]) begin
        if (fin) begin
          m_busy[k]  = 0;
          m_we[k]    = 0;
          m_rr[k]    = 1 - m_own[k];
          m_guard[k] = m_own[k];
          if (to) m_terr[k] = 1;
          n_done[k][m_own[k]]++;
        end else begin
          m_wait[k]++;
        end
      end else begin
        e0 = c_req[k][0] && m_guard[k] != 0;
        e1 = c_req[k][1] && m_guard[k] != 1;
        m_guard[k] = -1;
        if (e0 || e1) begin
          if (PM[k] == 1) w = e1 ? 1 : 0;
          else if (e0 && e1) w = m_rr[k];
          else w = e1 ? 1 : 0;
          m_busy[k]   = 1;
          m_own[k]    = w;
          m_wait[k]   = 0;
          m_we[k]     = c_we[k][w];
          m_addr[k]   = c_addr[k][w];
          m_wd[k]     = c_wd[k][w];
          lat_left[k] = $urandom_range(lat_max, lat_min);
        end
      end
    end
  endtask

  initial begin
    reset = 1;
    chk_en = 0;
    for (int k = 0; k < 2; k++) begin
      model_reset(k);
      lat_left[k] = -1;
      mem_rdy[k]  = 0;
      mem_rd[k]   = '0;
      for (int p = 0; p < 2; p++) begin
        c_req[k][p] = 0; c_we[k][p] = 0;
        c_addr[k][p] = '0; c_wd[k][p] = '0;
        hold[k][p] = 0; got_r[k][p] = 0;
        n_done[k][p] = 0;
      end
    end
    p_req = '{0, 0};
    fixed_mode = 0; lat_min = 0; lat_max = 0; data_fixed = 0;

    cycle(1);
    chk_en = 1;
    cycle(1);

    // Single icache read, fixed 3-cycle memory latency.
    p_req = '{100, 0}; fixed_mode = 1;
    lat_min = 3; lat_max = 3; data_fixed = 1;
    repeat (14) cycle(0);

    // Both ports hammer: c0 read 0x200, c1 write 0x300.
    p_req = '{100, 100}; fixed_mode = 2;
    lat_min = 0; lat_max = 2; data_fixed = 0;
    repeat (60) cycle(0);

    // Memory too slow for the 8-cycle watchdog.
    p_req = '{60, 60}; fixed_mode = 0;
    lat_min = 9; lat_max = 12;
    repeat (80) cycle(0);

    // Recovery traffic with the sticky error still set.
    lat_min = 0; lat_max = 5;
    repeat (60) cycle(0);

    // Reset landing mid-transaction, then the late mem_ready.
    lat_min = 4; lat_max = 6;
    for (int i = 0; i < 50 && !m_busy[0]; i++) cycle(0);
    check("busy_before_reset", 0, m_busy[0], 1);
    cycle(1);
    p_req = '{0, 0};
    repeat (10) cycle(0);

    // Random traffic with occasional resets.
    p_req = '{50, 50};
    lat_min = 0; lat_max = 10;
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(99, 0) < 2);

    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 2; p++)
        check("served", k, n_done[k][p] > 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
